// File: rtl/icg_en_ctrl.sv
// Idle-timeout clock-gate enable controller.
// Counts consecutive idle cycles of the gated block and drops the ICG enable
// once the programmable threshold is reached. A wake request or a gate disable
// restores the clock. clk_rdy is held low for WAKE_LAT settle cycles.
// All logic runs on the free-running clock.
module icg_en_ctrl #(
    parameter int IDLE_CNT_W = 8,
    parameter int WAKE_LAT   = 2,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  busy,
    input  logic                  wake_req,
    input  logic [IDLE_CNT_W-1:0] cfg_idle_thresh,
    input  logic                  cfg_gate_dis,
    output logic                  icg_en,
    output logic                  clk_rdy,
    output logic                  gated,
    output logic [CNT_W-1:0]      gate_cnt
);

    // The settle counter must hold WAKE_LAT-1; keep at least one bit so the
    // WAKE_LAT=0 build (where WAKE is unreachable) still elaborates cleanly.
    localparam int WL_W = (WAKE_LAT > 1) ? $clog2(WAKE_LAT) : 1;
    localparam logic [WL_W-1:0] WAKE_LAST = WL_W'((WAKE_LAT > 0) ? WAKE_LAT - 1 : 0);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_GATED = 2'd1,
        ST_WAKE  = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [IDLE_CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic [WL_W-1:0]         wake_cnt_q, wake_cnt_d;
    logic [CNT_W-1:0]        gate_cnt_q, gate_cnt_d;
    logic                    icg_en_q, icg_en_d;
    logic                    clk_rdy_q, clk_rdy_d;
    logic                    gated_q, gated_d;

    logic                    idle;
    logic [IDLE_CNT_W:0]     idle_cnt_inc;
    logic                    thresh_hit;

    // Idle qualification and live threshold compare; the extra bit keeps
    // idle_cnt+1 from wrapping when the counter sits at all-ones.
    always_comb begin
        idle         = !busy && !wake_req && !cfg_gate_dis && (cfg_idle_thresh != '0);
        idle_cnt_inc = {1'b0, idle_cnt_q} + (IDLE_CNT_W+1)'(1);
        thresh_hit   = idle_cnt_inc >= {1'b0, cfg_idle_thresh};
    end

    // Next-state, counters and registered-output values.
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        wake_cnt_d = wake_cnt_q;
        gate_cnt_d = gate_cnt_q;

        case (state_q)
            ST_RUN: begin
                if (idle && thresh_hit) begin
                    state_d    = ST_GATED;
                    idle_cnt_d = '0;
                    if (gate_cnt_q != '1) begin
                        gate_cnt_d = gate_cnt_q + CNT_W'(1);
                    end
                end else if (idle) begin
                    idle_cnt_d = idle_cnt_inc[IDLE_CNT_W-1:0];
                end else begin
                    idle_cnt_d = '0;
                end
            end
            ST_GATED: begin
                // busy is frozen in the gated domain, so only wake sources matter.
                idle_cnt_d = '0;
                if (wake_req || cfg_gate_dis) begin
                    if (WAKE_LAT > 0) begin
                        state_d    = ST_WAKE;
                        wake_cnt_d = '0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_WAKE: begin
                // Settle sequence always runs to completion, even if wake_req drops.
                idle_cnt_d = '0;
                if (wake_cnt_q == WAKE_LAST) begin
                    state_d    = ST_RUN;
                    wake_cnt_d = '0;
                end else begin
                    wake_cnt_d = wake_cnt_q + WL_W'(1);
                end
            end
            default: begin
                state_d    = ST_RUN;
                idle_cnt_d = '0;
                wake_cnt_d = '0;
            end
        endcase

        // Outputs are decoded from the next state so they are pure flop outputs.
        icg_en_d  = (state_d != ST_GATED);
        clk_rdy_d = (state_d == ST_RUN);
        gated_d   = (state_d == ST_GATED);
    end

    // State and output registers with synchronous reset to the clock-running state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            idle_cnt_q <= '0;
            wake_cnt_q <= '0;
            gate_cnt_q <= '0;
            icg_en_q   <= 1'b1;
            clk_rdy_q  <= 1'b1;
            gated_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            wake_cnt_q <= wake_cnt_d;
            gate_cnt_q <= gate_cnt_d;
            icg_en_q   <= icg_en_d;
            clk_rdy_q  <= clk_rdy_d;
            gated_q    <= gated_d;
        end
    end

    assign icg_en   = icg_en_q;
    assign clk_rdy  = clk_rdy_q;
    assign gated    = gated_q;
    assign gate_cnt = gate_cnt_q;

endmodule
